rz_tx_scheduler: RTL

RZ_TX_SCHEDULER -- requirements
Module: rz_tx_scheduler

---
 rtl/rz_tx_scheduler.sv | 109 ++++++++++
 1 files changed

// File: rtl/rz_tx_scheduler.sv
// Round-robin scheduler that feeds one payload at a time to an RZ UART transmitter; RZ_TX_SCHED_STATS_EN adds frame_count.
// Latency: accept in cycle N -> tx_valid in N+1 -> next accept no earlier than N+FRAME_CYCLES+1.
// Backpressure: req_ready is only offered in IDLE with sched_en high; a frame in flight always runs to completion.
module rz_tx_scheduler #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REQ      = 4,
    parameter int FRAME_CYCLES = 10
) (
    input  logic                          tx_clk,
    input  logic                          reset_n,
    input  logic                          sched_en,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
`ifdef RZ_TX_SCHED_STATS_EN
    ,
    output logic [15:0]                   frame_count
`endif
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(FRAME_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t                state;
    logic [IDW-1:0]        last_ptr;
    logic [CW-1:0]         hold_cnt;
    logic                  win_found;
    logic [IDW-1:0]        win_idx;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  accept;

    // Search upward from the requester after the last grant, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [IDW-1:0] cand;
            cand = IDW'((int'(last_ptr) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == win_idx) begin
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept    = (state == IDLE) && sched_en && win_found;
    assign req_ready = (accept && reset_n) ? (NUM_REQ'(1) << win_idx) : '0;

    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            last_ptr <= IDW'(NUM_REQ - 1);
`ifdef RZ_TX_SCHED_STATS_EN
            frame_count <= '0;
`endif
        end else begin
            tx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= ISSUE;
                        tx_valid <= 1'b1;
                        tx_data  <= win_data;
                        grant_id <= win_idx;
                        last_ptr <= win_idx;
                        busy     <= 1'b1;
`ifdef RZ_TX_SCHED_STATS_EN
                        frame_count <= frame_count + 16'd1;
`endif
                    end
                end
                ISSUE: begin
                    state    <= HOLD;
                    hold_cnt <= CW'(FRAME_CYCLES - 1);
                end
                HOLD: begin
                    // Last HOLD cycle: the frame has occupied the line for FRAME_CYCLES cycles.
                    if (hold_cnt == CW'(1)) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                        busy     <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
